// File: rtl/sd_cic_decimator.sv
// sd_cic_decimator
//   Third-order CIC decimator for the ternary symbol stream produced by the
//   two-piece sigma-delta modulator. Integrators run at the input rate
//   (only on qualified samples), combs run once per DECIM accepted samples.
//   Arithmetic wraps modulo 2^W; the output is exact whenever the true
//   result fits in W signed bits (gain is DECIM^3).
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high; clears all state
//   sd_in      ternary symbol: 01 -> +1, 10 -> -1, 00/11 -> 0
//   in_valid   qualifies sd_in this cycle
//   dec_out    signed two's-complement decimated sample (held between pulses)
//   out_valid  one-cycle pulse marking a new dec_out
module sd_cic_decimator #(
  parameter  int DECIM = 64,
  localparam int W     = 3 * $clog2(DECIM) + 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   sd_in,
  input  logic         in_valid,
  output logic [W-1:0] dec_out,
  output logic         out_valid
);

  localparam int CW = $clog2(DECIM);

  logic [W-1:0]        x;
  logic [2:0][W-1:0]   integ_q, integ_d;
  logic [2:0][W-1:0]   dly_q, dly_d;
  logic [2:0][W-1:0]   comb;
  logic [CW-1:0]       cnt_q, cnt_d;
  // [0] = frame tick, [1] = out_valid
  logic [1:0]          vld_pipe_q, vld_pipe_d;
  logic [W-1:0]        dout_q, dout_d;

  always_comb begin
    x = '0;
    case (sd_in)
      2'b01:   x = {{(W-1){1'b0}}, 1'b1};
      2'b10:   x = {W{1'b1}};
      default: x = '0;
    endcase

    // Each integrator adds the previous stage's just-updated value.
    integ_d = integ_q;
    cnt_d   = cnt_q;
    if (in_valid) begin
      integ_d[0] = integ_q[0] + x;
      for (int i = 1; i < 3; i++)
        integ_d[i] = integ_q[i] + integ_d[i-1];
      // DECIM is a power of two, so the counter wraps on its own.
      cnt_d = cnt_q + 1'b1;
    end

    vld_pipe_d[0] = in_valid && (cnt_q == {CW{1'b1}});
    vld_pipe_d[1] = vld_pipe_q[0];

    // Combs work on the registered last integrator, so a sample accepted on
    // the tick edge itself belongs to the next frame.
    comb[0] = integ_q[2] - dly_q[0];
    for (int i = 1; i < 3; i++)
      comb[i] = comb[i-1] - dly_q[i];

    dly_d  = dly_q;
    dout_d = dout_q;
    if (vld_pipe_q[0]) begin
      dly_d  = {comb[1], comb[0], integ_q[2]};
      dout_d = comb[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      integ_q    <= '0;
      dly_q      <= '0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      dout_q     <= '0;
    end else begin
      integ_q    <= integ_d;
      dly_q      <= dly_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      dout_q     <= dout_d;
    end
  end

  assign dec_out   = dout_q;
  assign out_valid = vld_pipe_q[1];

endmodule

// File: tb/tb_sd_cic_decimator.sv
module tb_sd_cic_decimator;

  localparam int D = 64;
  localparam int W = 3 * $clog2(D) + 2;
  localparam int K = 3 * D - 2;   // CIC impulse response length

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   sd_in = 2'b00;
  logic         in_valid = 1'b0;
  logic [W-1:0] dec_out;
  logic         out_valid;

  sd_cic_decimator #(.DECIM(D)) dut (
    .clk(clk), .reset(reset), .sd_in(sd_in), .in_valid(in_valid),
    .dec_out(dec_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] val;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           hist[$];     // accepted samples, newest first
  int           h[K];
  int           phase = 0;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  bit           mon_en = 0;
  logic [W-1:0] hold_ref = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) hold_ref <= '0;
  end

  // Output monitor: every pulse must match the scoreboard head in value and
  // cycle; between pulses dec_out must hold the last value.
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if (out_valid) begin
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse cyc=%0d dec_out=%0d", cyc, $signed(dec_out));
        end else begin
          exp_t e;
          e = q.pop_front();
          if (dec_out !== e.val || cyc != e.due) begin
            n_fail++;
            $display("FAIL pulse got=%0d@%0d exp=%0d@%0d", $signed(dec_out), cyc,
                     $signed(e.val), e.due);
          end
          hold_ref = e.val;
        end
      end else if (dec_out !== hold_ref) begin
        n_fail++;
        $display("FAIL hold cyc=%0d got=%0d exp=%0d", cyc, $signed(dec_out), $signed(hold_ref));
      end
    end
  end

  function automatic int sym(input logic [1:0] s);
    return (s == 2'b01) ? 1 : (s == 2'b10) ? -1 : 0;
  endfunction

  // Direct-form reference: convolution of the recent input with the
  // triple-boxcar impulse response, reduced modulo 2^W.
  function automatic logic [W-1:0] model_out();
    int acc = 0;
    for (int k = 0; k < hist.size() && k < K; k++) acc += h[k] * hist[k];
    return acc[W-1:0];
  endfunction

  task automatic drive(input logic [1:0] sd, input logic v);
    sd_in = sd;
    in_valid = v;
    if (v) begin
      hist.push_front(sym(sd));
      if (hist.size() > 3 * D) void'(hist.pop_back());
      if (phase == D - 1) begin
        phase = 0;
        q.push_back('{val: model_out(), due: cyc + 2});
      end else begin
        phase++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d exp=0", q.size());
    end
  endtask

  task automatic check_out(input string name, input int exp_v);
    logic [W-1:0] e;
    e = exp_v[W-1:0];
    n_chk++;
    if (dec_out !== e) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, $signed(dec_out), exp_v);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    sd_in = 2'bxx;
    in_valid = 1'b1;
    q.delete();
    hist.delete();
    phase = 0;
    repeat (cycles) begin @(posedge clk); #1; end
    n_chk++;
    if (out_valid !== 1'b0 || dec_out !== '0) begin
      n_fail++;
      $display("FAIL reset_clear out_valid=%b dec_out=%0d exp 0/0", out_valid, $signed(dec_out));
    end
    reset = 1'b0;
    in_valid = 1'b0;
    sd_in = 2'b00;
    mon_en = 1;
  endtask

  task automatic test_reset();
    do_reset(3);
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic test_const(input logic [1:0] sd, input int frames, input int exp_v);
    repeat (frames * D) drive(sd, 1'b1);
    drain();
    check_out($sformatf("const_%b", sd), exp_v);
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 5 * D; i++) drive((i % 2) ? 2'b10 : 2'b01, 1'b1);
    drain();
    check_out("alternating", 0);
  endtask

  task automatic test_valid_toggle();
    for (int i = 0; i < 10 * D; i++) drive(2'b01, (i % 2) == 0);
    drain();
    check_out("valid_toggle", D * D * D);
    // Long idle gap: the monitor flags any pulse or change of dec_out.
    repeat (1000) drive(2'b10, 1'b0);
    check_out("idle_gap", D * D * D);
    repeat (4 * D) drive(2'b01, 1'b1);
    drain();
    check_out("after_gap", D * D * D);
  endtask

  task automatic test_random();
    int frames = 0;
    while (frames < 8) begin
      logic v;
      logic [1:0] s;
      v = ($urandom_range(0, 3) != 0);
      s = 2'($urandom_range(0, 3));
      if (v && phase == D - 1) frames++;
      drive(s, v);
    end
    drain();
  endtask

  task automatic test_reset_midframe();
    repeat (30) drive(2'b01, 1'b1);
    do_reset(1);
    // First pulse must come exactly D accepted samples after release.
    repeat (5 * D) drive(2'b01, 1'b1);
    drain();
    check_out("post_reset", D * D * D);
  endtask

  task automatic test_wrap();
    repeat (300 * D) drive(2'b01, 1'b1);
    drain();
    check_out("wrap", D * D * D);
  endtask

  initial begin
    // Impulse response of three cascaded length-D boxcars.
    int b2[2*D-1];
    for (int k = 0; k < 2 * D - 1; k++) b2[k] = (k < D) ? k + 1 : 2 * D - 1 - k;
    for (int k = 0; k < K; k++) begin
      h[k] = 0;
      for (int j = 0; j < D; j++)
        if (k - j >= 0 && k - j < 2 * D - 1) h[k] += b2[k - j];
    end

    @(posedge clk); #1;
    test_reset();
    test_const(2'b01, 6, D * D * D);
    test_const(2'b10, 5, -(D * D * D));
    test_const(2'b00, 4, 0);
    test_const(2'b11, 4, 0);
    test_alternating();
    test_valid_toggle();
    test_random();
    test_reset_midframe();
    test_wrap();
    repeat (3) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
